// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the serial pattern-scan sequencer.
package pattern_scan_pkg;

   localparam int unsigned MAX_LEN_DEF = 8;
   localparam int unsigned LEN_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Never returns less than 1 so tiny counters still get a real bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic [LEN_W-1:0] clamp_len(
      input logic [LEN_W-1:0] len,
      input int unsigned      max_len
   );
      if (len < LEN_W'(2)) return LEN_W'(2);
      if (32'(len) > max_len) return LEN_W'(max_len);
      return len;
   endfunction

endpackage

// File: rtl/pattern_scan_if.sv
// Control/status bundle between the button front end and the scan sequencer.
interface pattern_scan_if
   import pattern_scan_pkg::*;
#(
   parameter int unsigned MAX_LEN = MAX_LEN_DEF,
   parameter int unsigned CNT_W   = 8
);

   logic               bit_in;
   logic               start;
   logic               stop;
   logic [LEN_W-1:0]   pat_len;
   logic [MAX_LEN-1:0] pat_val;
   logic               overlap;
   logic               sample_stb;
   logic               busy;
   logic [MAX_LEN-1:0] shift_q;
   logic               match;
   logic               det_led;
   logic [CNT_W-1:0]   match_cnt;

   modport master (
      output bit_in,
      output start,
      output stop,
      output pat_len,
      output pat_val,
      output overlap,
      input  sample_stb,
      input  busy,
      input  shift_q,
      input  match,
      input  det_led,
      input  match_cnt
   );

   modport slave (
      input  bit_in,
      input  start,
      input  stop,
      input  pat_len,
      input  pat_val,
      input  overlap,
      output sample_stb,
      output busy,
      output shift_q,
      output match,
      output det_led,
      output match_cnt
   );

endinterface

// File: rtl/tick_gen.sv
// Sample-strobe generator: one-cycle pulse every TICK_DIV clocks while enabled.
module tick_gen
   import pattern_scan_pkg::*;
#(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic stb
);

   localparam int unsigned   CW   = clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // An abort in the strobe cycle suppresses the sample.
   assign stb = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern-detection sequencer: strobe-sampled history, compare, hold LED.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 25_000_000,
   parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
   parameter int unsigned HOLD_TICKS = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic           clk,
   input  logic           rst,
   pattern_scan_if.slave  bus
);

   localparam int unsigned FW = clog2(MAX_LEN + 1);
   localparam int unsigned HW = clog2(HOLD_TICKS + 1);

   state_e             state_q;
   state_e             state_d;
   logic [FW-1:0]      fill_q;
   logic [FW-1:0]      fill_d;
   logic [HW-1:0]      hold_q;
   logic [HW-1:0]      hold_d;
   logic [MAX_LEN-1:0] sh_q;
   logic [MAX_LEN-1:0] sh_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] pat_d;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   len_d;
   logic               ovl_q;
   logic               ovl_d;
   logic               match_q;
   logic               match_d;
   logic               led_q;
   logic               led_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic               busy;
   logic               stb;
   logic               tick_clr;
   logic               cmp;
   logic               hit;
   logic               fill_last;
   logic [MAX_LEN-1:0] new_sh;
   logic [MAX_LEN-1:0] mask;

   assign busy     = (state_q != IDLE);
   assign tick_clr = bus.stop | ((state_q == IDLE) & bus.start);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .clr (tick_clr),
      .en  (busy),
      .stb (stb)
   );

   always_comb begin
      new_sh = {sh_q[MAX_LEN-2:0], bus.bit_in};
      mask   = '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         mask[i] = (i < int'(len_q));
      end
      hit       = ((new_sh ^ pat_q) & mask) == '0;
      fill_last = (fill_q == FW'(len_q - LEN_W'(1)));
   end

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      hold_d  = hold_q;
      sh_d    = sh_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      match_d = 1'b0;
      led_d   = led_q;
      cnt_d   = cnt_q;
      cmp     = 1'b0;

      if (bus.stop) begin
         state_d = IDLE;
         fill_d  = '0;
         hold_d  = '0;
         led_d   = 1'b0;
         sh_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  len_d   = clamp_len(bus.pat_len, MAX_LEN);
                  pat_d   = bus.pat_val;
                  ovl_d   = bus.overlap;
                  fill_d  = '0;
                  sh_d    = '0;
                  state_d = FILL;
               end
            end
            FILL: begin
               if (stb) begin
                  sh_d   = new_sh;
                  fill_d = fill_q + FW'(1);
                  if (fill_last) begin
                     cmp     = 1'b1;
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (stb) begin
                  sh_d = new_sh;
                  cmp  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (cmp && hit) begin
            match_d = 1'b1;
            led_d   = 1'b1;
            hold_d  = HW'(HOLD_TICKS);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            // Non-overlapping mode restarts the window from scratch.
            if (!ovl_q) begin
               fill_d  = '0;
               state_d = FILL;
            end
         end else if (stb && (hold_q != '0)) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) led_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fill_q  <= '0;
         hold_q  <= '0;
         sh_q    <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         match_q <= 1'b0;
         led_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         hold_q  <= hold_d;
         sh_q    <= sh_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         match_q <= match_d;
         led_q   <= led_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.sample_stb = stb;
   assign bus.busy       = busy;
   assign bus.shift_q    = sh_q;
   assign bus.match      = match_q;
   assign bus.det_led    = led_q;
   assign bus.match_cnt  = cnt_q;

endmodule
